// File: rtl/trash_pkg.sv
// Shared constants and loader state encoding for the program-memory feeder.
package trash_pkg;

  localparam int PROG_BYTES = 8;
  localparam int ADDR_W     = $clog2(PROG_BYTES);

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_DATA = 2'd1,
    LD_CHK  = 2'd2
  } ld_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin strobe, followed by a
// registered one-cycle pulse on each synchronised rising edge.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: every sequential update uses <= so all flops sample the same
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
      pulse  <= sync_q[STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Receives a LEN / data / CHK framed program from the pins, writes it into
// program memory and flags it valid once the XOR checksum matches.
module prog_loader #(
  parameter  int PROG_BYTES  = trash_pkg::PROG_BYTES,
  parameter  int SYNC_STAGES = 2,
  localparam int ADDR_W      = $clog2(PROG_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_n,
  input  logic              in_strobe,
  input  logic [7:0]        in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic              prog_valid,
  output logic [ADDR_W:0]   prog_len
);

  import trash_pkg::*;

  ld_state_t       state;
  logic            byte_edge;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] cnt_next;
  logic [7:0]      xor_q;
  logic            len_ok;

  sync_edge #(.STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (in_strobe),
    .pulse    (byte_edge)
  );

  assign cnt_next = cnt_q + 1'b1;
  assign len_ok   = (in_data != 8'd0) && (in_data <= 8'(PROG_BYTES));
  assign busy     = (state != LD_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LD_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      xor_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      prog_valid <= 1'b0;
      prog_len   <= '0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      unique case (state)
        LD_IDLE: begin
          // Strobes in execution mode are dropped; a valid program is kept.
          if (byte_edge && !prog_n) begin
            if (len_ok) begin
              prog_valid <= 1'b0;
              len_q      <= in_data[ADDR_W:0];
              xor_q      <= in_data;
              cnt_q      <= '0;
              state      <= LD_DATA;
            end else begin
              load_err <= 1'b1;
            end
          end
        end
        LD_DATA: begin
          if (prog_n) begin
            load_err <= 1'b1;
            state    <= LD_IDLE;
          end else if (byte_edge) begin
            mem_we    <= 1'b1;
            mem_addr  <= cnt_q[ADDR_W-1:0];
            mem_wdata <= in_data;
            xor_q     <= xor_q ^ in_data;
            cnt_q     <= cnt_next;
            if (cnt_next == len_q) state <= LD_CHK;
          end
        end
        LD_CHK: begin
          if (prog_n) begin
            load_err <= 1'b1;
            state    <= LD_IDLE;
          end else if (byte_edge) begin
            if (in_data == xor_q) begin
              prog_valid <= 1'b1;
              prog_len   <= len_q;
              load_done  <= 1'b1;
            end else begin
              load_err <= 1'b1;
            end
            state <= LD_IDLE;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expected memory writes and
// done/error pulses, a negedge monitor pops and compares them as they appear.
module tb_prog_loader;

  localparam int SYNC_STAGES = 2;
  localparam int ADDR_W      = 3;

  localparam logic [1:0] EV_WR   = 2'd0;
  localparam logic [1:0] EV_DONE = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  typedef struct {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              pv;
    logic [ADDR_W:0]   plen;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              prog_n;
  logic              in_strobe;
  logic [7:0]        in_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              load_done;
  logic              load_err;
  logic              prog_valid;
  logic [ADDR_W:0]   prog_len;
  logic              any_out;

  int  n_pass = 0;
  int  n_total = 0;
  ev_t exp_q[$];

  assign any_out = mem_we | load_done | load_err;

  always #5 clk = ~clk;

  prog_loader #(.PROG_BYTES(8), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_n     (prog_n),
    .in_strobe  (in_strobe),
    .in_data    (in_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .prog_valid (prog_valid),
    .prog_len   (prog_len)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = EV_WR; e.addr = a; e.data = d; e.pv = 1'b0; e.plen = '0;
    exp_q.push_back(e);
  endtask

  task automatic exp_ev(input logic [1:0] k, input logic pv, input logic [ADDR_W:0] plen);
    ev_t e;
    e.kind = k; e.addr = '0; e.data = '0; e.pv = pv; e.plen = plen;
    exp_q.push_back(e);
  endtask

  // One strobe pulse; optionally checks that the response lands exactly
  // SYNC_STAGES+2 edges after the first edge that sees the strobe high.
  task automatic send_byte(input logic [7:0] b, input bit chk_lat = 1'b0);
    @(negedge clk);
    in_data   = b;
    in_strobe = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
      @(posedge clk);
      #1;
      if (chk_lat && k == SYNC_STAGES + 1) check("latency_early", any_out, 0);
      if (chk_lat && k == SYNC_STAGES + 2) check("latency_edge", any_out, 1);
    end
    @(negedge clk);
    in_strobe = 1'b0;
    repeat (SYNC_STAGES + 3) @(negedge clk);
  endtask

  task automatic send_good_3();
    exp_wr(3'd0, 8'hA1); exp_wr(3'd1, 8'hB2); exp_wr(3'd2, 8'hC3);
    exp_ev(EV_DONE, 1'b1, 4'd3);
    send_byte(8'h03);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD3, 1'b1);
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset && any_out) begin
        check("one_pulse_only", $countones({mem_we, load_done, load_err}), 1);
        check("sb_has_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ev_kind", mem_we ? EV_WR : (load_done ? EV_DONE : EV_ERR), e.kind);
          if (e.kind == EV_WR) begin
            check("wr_addr", mem_addr, e.addr);
            check("wr_data", mem_wdata, e.data);
          end else begin
            check("ev_prog_valid", prog_valid, e.pv);
            check("ev_prog_len", prog_len, e.plen);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    prog_n    = 1'b0;
    in_strobe = 1'b0;
    in_data   = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_mem_we", mem_we, 0);
    check("rst_outputs", {busy, load_done, load_err, prog_valid, prog_len, mem_addr, mem_wdata}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Good 3-byte frame.
    send_good_3();
    check("t1_valid", prog_valid, 1);
    check("t1_len", prog_len, 3);
    check("t1_idle", busy, 0);

    // Bad checksum: writes still happen, program invalid.
    exp_wr(3'd0, 8'hA1); exp_wr(3'd1, 8'hB2); exp_wr(3'd2, 8'hC3);
    exp_ev(EV_ERR, 1'b0, 4'd3);
    send_byte(8'h03);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'h00);
    check("t2_invalid", prog_valid, 0);

    // Reload, then illegal LEN values keep the valid program.
    send_good_3();
    exp_ev(EV_ERR, 1'b1, 4'd3);
    send_byte(8'h00, 1'b1);
    exp_ev(EV_ERR, 1'b1, 4'd3);
    send_byte(8'h09);
    check("t3_valid_kept", prog_valid, 1);
    check("t3_idle", busy, 0);

    // Full-depth frame 00..07, checksum 08.
    exp_ev(EV_DONE, 1'b1, 4'd8);
    for (int i = 0; i < 8; i++) exp_wr(3'(i), 8'(i));
    begin
      ev_t d;
      d = exp_q.pop_front();
      exp_q.push_back(d);
    end
    send_byte(8'h08);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    send_byte(8'h08);
    check("t4_len", prog_len, 8);

    // Abort by leaving programming mode mid-frame.
    exp_wr(3'd0, 8'h11); exp_wr(3'd1, 8'h22);
    exp_ev(EV_ERR, 1'b0, 4'd8);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    prog_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_invalid", prog_valid, 0);
    prog_n = 1'b0;
    exp_wr(3'd0, 8'h5A); exp_wr(3'd1, 8'hA5);
    exp_ev(EV_DONE, 1'b1, 4'd2);
    send_byte(8'h02);
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'hFD);
    check("t5_reload_len", prog_len, 2);

    // Strobes in execution mode are ignored.
    prog_n = 1'b1;
    send_byte(8'h03);
    send_byte(8'h01);
    check("t6_exec_idle", busy, 0);
    check("t6_exec_valid", {prog_valid, prog_len}, {1'b1, 4'd2});
    prog_n = 1'b0;
    repeat (4) @(negedge clk);

    // Strobe held high for 20 cycles accepts only one byte (LEN=2).
    in_data   = 8'h02;
    in_strobe = 1'b1;
    repeat (20) @(negedge clk);
    in_strobe = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_held_busy", busy, 1);
    exp_wr(3'd0, 8'h77);
    send_byte(8'h77);

    // Reset in the middle of DATA clears everything on the next cycle.
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_we", mem_we, 0);
    check("t6_rst_outputs", {busy, load_done, load_err, prog_valid, prog_len, mem_addr, mem_wdata}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
